// File: rtl/return_stack_if.sv
// Command and status bundle between the A09 control matrix (master) and the
// return-address stack (slave).
interface return_stack_if #(
    parameter int DataWidth  = 8,
    parameter int Depth      = 4,
    parameter int CountWidth = $clog2(Depth + 1)
);
    // Handshake: Clr/Push/Pop are single-cycle strobes with no ready. Every
    // asserted request is consumed on the rising edge where it is sampled;
    // requests the stack cannot honour are reported through the sticky flags.
    logic                  Clr;
    logic                  Push;
    logic                  Pop;
    logic [DataWidth-1:0]  DIn;
    logic [DataWidth-1:0]  DOut;
    logic [CountWidth-1:0] Count;
    logic                  Empty;
    logic                  Full;
    logic                  Overflow;
    logic                  Underflow;

    modport master (
        output Clr, Push, Pop, DIn,
        input  DOut, Count, Empty, Full, Overflow, Underflow
    );

    modport slave (
        input  Clr, Push, Pop, DIn,
        output DOut, Count, Empty, Full, Overflow, Underflow
    );
endinterface

// File: rtl/return_stack.sv
// LIFO return-address stack for nested JPL/RET: push on link, pop on RET,
// push+pop replaces the top entry for tail calls.
module return_stack #(
    parameter int DataWidth      = 8,
    parameter int Depth          = 4,
    parameter bit WrapOnOverflow = 1'b0,
    parameter int CountWidth     = $clog2(Depth + 1)
) (
    input logic           Clk,
    input logic           Reset,
    return_stack_if.slave bus
);
    localparam int PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth-1:0]   LastIdx   = PtrWidth'(Depth - 1);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

    logic [DataWidth-1:0]  mem [Depth];
    logic [PtrWidth-1:0]   sp;
    logic [PtrWidth-1:0]   sp_next;
    logic [PtrWidth-1:0]   sp_inc;
    logic [PtrWidth-1:0]   sp_dec;
    logic [PtrWidth-1:0]   wr_idx;
    logic [CountWidth-1:0] count;
    logic [CountWidth-1:0] count_next;
    logic                  overflow;
    logic                  underflow;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  do_write;
    logic                  is_empty;
    logic                  is_full;

    // Explicit wrap so non-power-of-two depths stay inside 0..Depth-1.
    assign sp_inc = (sp == LastIdx) ? '0 : sp + PtrWidth'(1);
    assign sp_dec = (sp == '0) ? LastIdx : sp - PtrWidth'(1);

    assign is_empty = (count == '0);
    assign is_full  = (count == FullCount);

    always_comb begin
        sp_next    = sp;
        count_next = count;
        wr_idx     = sp;
        do_write   = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (bus.Push && bus.Pop && !is_empty) begin
            do_write = 1'b1;
            wr_idx   = sp_dec;
        end else if (bus.Push) begin
            if (!is_full) begin
                do_write   = 1'b1;
                sp_next    = sp_inc;
                count_next = count + CountWidth'(1);
            end else begin
                ovf_set = 1'b1;
                if (WrapOnOverflow) begin
                    // The slot at Sp holds the oldest entry when full.
                    do_write = 1'b1;
                    sp_next  = sp_inc;
                end
            end
        end else if (bus.Pop) begin
            if (!is_empty) begin
                sp_next    = sp_dec;
                count_next = count - CountWidth'(1);
            end else begin
                unf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || bus.Clr) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            count     <= count_next;
            overflow  <= overflow | ovf_set;
            underflow <= underflow | unf_set;
        end
    end

    // Storage has no reset; stale entries are masked by the empty check on DOut.
    always_ff @(posedge Clk) begin
        if (!Reset && !bus.Clr && do_write) begin
            mem[wr_idx] <= bus.DIn;
        end
    end

    assign bus.DOut      = is_empty ? '0 : mem[sp_dec];
    assign bus.Count     = count;
    assign bus.Empty     = is_empty;
    assign bus.Full      = is_full;
    assign bus.Overflow  = overflow;
    assign bus.Underflow = underflow;
endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: three configurations share one command stream and
// are compared against a shift-array stack model plus directed scenarios.
module tb_return_stack;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        push;
    logic        pop;
    logic [15:0] din;

    int n_checks = 0;
    int n_pass   = 0;

    // ---- clock / reset block ----
    always #5 clk = ~clk;

    // ---- three configurations: saturating d4, wrapping d4, wrapping d3 x16 ----
    return_stack_if #(.DataWidth(8),  .Depth(4)) if_sat ();
    return_stack_if #(.DataWidth(8),  .Depth(4)) if_wrp ();
    return_stack_if #(.DataWidth(16), .Depth(3)) if_d3 ();

    assign if_sat.Clr = clr;  assign if_sat.Push = push;  assign if_sat.Pop = pop;  assign if_sat.DIn = din[7:0];
    assign if_wrp.Clr = clr;  assign if_wrp.Push = push;  assign if_wrp.Pop = pop;  assign if_wrp.DIn = din[7:0];
    assign if_d3.Clr  = clr;  assign if_d3.Push  = push;  assign if_d3.Pop  = pop;  assign if_d3.DIn  = din;

    return_stack #(.DataWidth(8), .Depth(4), .WrapOnOverflow(1'b0)) u_sat (
        .Clk(clk), .Reset(rst), .bus(if_sat.slave));
    return_stack #(.DataWidth(8), .Depth(4), .WrapOnOverflow(1'b1)) u_wrp (
        .Clk(clk), .Reset(rst), .bus(if_wrp.slave));
    return_stack #(.DataWidth(16), .Depth(3), .WrapOnOverflow(1'b1)) u_d3 (
        .Clk(clk), .Reset(rst), .bus(if_d3.slave));

    logic [15:0] obs_dout  [3];
    logic [3:0]  obs_cnt   [3];
    logic        obs_empty [3];
    logic        obs_full  [3];
    logic        obs_ovf   [3];
    logic        obs_unf   [3];

    assign obs_dout[0] = {8'h00, if_sat.DOut};
    assign obs_dout[1] = {8'h00, if_wrp.DOut};
    assign obs_dout[2] = if_d3.DOut;
    assign obs_cnt[0]  = {1'b0, if_sat.Count};
    assign obs_cnt[1]  = {1'b0, if_wrp.Count};
    assign obs_cnt[2]  = {2'b00, if_d3.Count};
    assign obs_empty[0] = if_sat.Empty;  assign obs_empty[1] = if_wrp.Empty;  assign obs_empty[2] = if_d3.Empty;
    assign obs_full[0]  = if_sat.Full;   assign obs_full[1]  = if_wrp.Full;   assign obs_full[2]  = if_d3.Full;
    assign obs_ovf[0]   = if_sat.Overflow;  assign obs_ovf[1] = if_wrp.Overflow;  assign obs_ovf[2] = if_d3.Overflow;
    assign obs_unf[0]   = if_sat.Underflow; assign obs_unf[1] = if_wrp.Underflow; assign obs_unf[2] = if_d3.Underflow;

    // ---- reference model: entries kept oldest-first, top at index cnt-1 ----
    int          dep [3] = '{4, 4, 3};
    bit          wrp [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] msk [3] = '{16'h00ff, 16'h00ff, 16'hffff};
    logic [15:0] m_stk [3][4];
    int          m_cnt [3];
    bit          m_ovf [3];
    bit          m_unf [3];

    function automatic void model_update(input bit r, input bit c, input bit pu, input bit po,
                                         input logic [15:0] d);
        for (int k = 0; k < 3; k++) begin
            logic [15:0] v;
            v = d & msk[k];
            if (r || c) begin
                m_cnt[k] = 0;
                m_ovf[k] = 1'b0;
                m_unf[k] = 1'b0;
            end else if (pu && po && m_cnt[k] > 0) begin
                m_stk[k][m_cnt[k]-1] = v;
            end else if (pu) begin
                if (m_cnt[k] < dep[k]) begin
                    m_stk[k][m_cnt[k]] = v;
                    m_cnt[k]++;
                end else begin
                    m_ovf[k] = 1'b1;
                    if (wrp[k]) begin
                        for (int j = 0; j < dep[k] - 1; j++) m_stk[k][j] = m_stk[k][j+1];
                        m_stk[k][dep[k]-1] = v;
                    end
                end
            end else if (po) begin
                if (m_cnt[k] > 0) m_cnt[k]--;
                else m_unf[k] = 1'b1;
            end
        end
    endfunction

    function automatic logic [15:0] model_top(input int k);
        return (m_cnt[k] == 0) ? 16'h0000 : m_stk[k][m_cnt[k]-1];
    endfunction

    // ---- driver tasks ----
    task automatic step(input bit r, input bit c, input bit pu, input bit po, input logic [15:0] d);
        rst = r; clr = c; push = pu; pop = po; din = d;
        @(posedge clk);
        model_update(r, c, pu, po, d);
        #1;
        rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] d);
        step(1'b0, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic do_pop();
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_dout[k] !== 16'h0 || obs_cnt[k] !== 4'd0 || obs_empty[k] !== 1'b1 ||
                obs_full[k] !== 1'b0 || obs_ovf[k] !== 1'b0 || obs_unf[k] !== 1'b0)
                $display("FAIL reset[%0d]: dout=%h cnt=%0d e=%b f=%b o=%b u=%b, want 0 0 1 0 0 0",
                         k, obs_dout[k], obs_cnt[k], obs_empty[k], obs_full[k], obs_ovf[k], obs_unf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_fill_drain();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 1; i <= 4; i++) do_push(16'(i * 16));
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_cnt[k] !== 4'd4 || obs_full[k] !== 1'b1 || obs_dout[k] !== 16'h0040 || obs_ovf[k] !== 1'b0)
                $display("FAIL fill[%0d]: cnt=%0d f=%b dout=%h o=%b, want 4 1 0040 0",
                         k, obs_cnt[k], obs_full[k], obs_dout[k], obs_ovf[k]);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_dout[k] !== 16'(16'h0040 - 16 * i))
                    $display("FAIL drain[%0d] pop %0d: dout=%h, want %h", k, i, obs_dout[k], 16'(16'h0040 - 16 * i));
                else n_pass++;
            end
            do_pop();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_empty[k] !== 1'b1 || obs_dout[k] !== 16'h0 || obs_cnt[k] !== 4'd0 ||
                obs_ovf[k] !== 1'b0 || obs_unf[k] !== 1'b0)
                $display("FAIL drained[%0d]: e=%b dout=%h cnt=%0d o=%b u=%b, want 1 0 0 0 0",
                         k, obs_empty[k], obs_dout[k], obs_cnt[k], obs_ovf[k], obs_unf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [15:0] top_exp [2];
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 1; i <= 5; i++) do_push(16'(i * 16));
        top_exp[0] = 16'h0040;
        top_exp[1] = 16'h0050;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_ovf[k] !== 1'b1 || obs_cnt[k] !== 4'd4 || obs_dout[k] !== top_exp[k])
                $display("FAIL overflow[%0d]: o=%b cnt=%0d dout=%h, want 1 4 %h",
                         k, obs_ovf[k], obs_cnt[k], obs_dout[k], top_exp[k]);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_dout[k] !== 16'(top_exp[k] - 16 * i))
                    $display("FAIL ovf_pop[%0d] %0d: dout=%h, want %h", k, i, obs_dout[k], 16'(top_exp[k] - 16 * i));
                else n_pass++;
            end
            do_pop();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_empty[k] !== 1'b1 || obs_dout[k] !== 16'h0 || obs_ovf[k] !== 1'b1)
                $display("FAIL ovf_sticky[%0d]: e=%b dout=%h o=%b, want 1 0 1", k, obs_empty[k], obs_dout[k], obs_ovf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_underflow_clear();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        do_pop();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_unf[k] !== 1'b1 || obs_cnt[k] !== 4'd0 || obs_empty[k] !== 1'b1)
                $display("FAIL underflow[%0d]: u=%b cnt=%0d e=%b, want 1 0 1", k, obs_unf[k], obs_cnt[k], obs_empty[k]);
            else n_pass++;
        end
        do_push(16'h0011);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_unf[k] !== 1'b1 || obs_dout[k] !== 16'h0011 || obs_cnt[k] !== 4'd1)
                $display("FAIL unf_sticky[%0d]: u=%b dout=%h cnt=%0d, want 1 0011 1", k, obs_unf[k], obs_dout[k], obs_cnt[k]);
            else n_pass++;
        end
        // Clear with a pending push: the push must be ignored.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0099);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_cnt[k] !== 4'd0 || obs_unf[k] !== 1'b0 || obs_dout[k] !== 16'h0 || obs_empty[k] !== 1'b1)
                $display("FAIL clear[%0d]: cnt=%0d u=%b dout=%h e=%b, want 0 0 0 1",
                         k, obs_cnt[k], obs_unf[k], obs_dout[k], obs_empty[k]);
            else n_pass++;
        end
    endtask

    task automatic test_replace();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        do_push(16'h0021);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0033);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_cnt[k] !== 4'd1 || obs_dout[k] !== 16'h0033)
                $display("FAIL replace[%0d]: cnt=%0d dout=%h, want 1 0033", k, obs_cnt[k], obs_dout[k]);
            else n_pass++;
        end
        do_pop();
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0044);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_cnt[k] !== 4'd1 || obs_dout[k] !== 16'h0044 || obs_unf[k] !== 1'b0)
                $display("FAIL replace_empty[%0d]: cnt=%0d dout=%h u=%b, want 1 0044 0",
                         k, obs_cnt[k], obs_dout[k], obs_unf[k]);
            else n_pass++;
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 1; i <= 4; i++) do_push(16'(i * 16));
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0055);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_cnt[k] !== 4'd4 || obs_dout[k] !== 16'h0055 || obs_ovf[k] !== 1'b0)
                $display("FAIL replace_full[%0d]: cnt=%0d dout=%h o=%b, want 4 0055 0",
                         k, obs_cnt[k], obs_dout[k], obs_ovf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_priority();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        do_push(16'h0001);
        do_push(16'h0002);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0077);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_cnt[k] !== 4'd0 || obs_empty[k] !== 1'b1 || obs_dout[k] !== 16'h0)
                $display("FAIL reset_prio[%0d]: cnt=%0d e=%b dout=%h, want 0 1 0",
                         k, obs_cnt[k], obs_empty[k], obs_dout[k]);
            else n_pass++;
        end
    endtask

    task automatic test_sweep_d3();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 1; i <= 3; i++) do_push(16'(i * 16'h1010));
        n_checks++;
        if (obs_cnt[2] !== 4'd3 || obs_full[2] !== 1'b1 || obs_dout[2] !== 16'h3030 || obs_ovf[2] !== 1'b0)
            $display("FAIL d3_fill: cnt=%0d f=%b dout=%h o=%b, want 3 1 3030 0", obs_cnt[2], obs_full[2], obs_dout[2], obs_ovf[2]);
        else n_pass++;
        for (int i = 3; i >= 1; i--) begin
            n_checks++;
            if (obs_dout[2] !== 16'(i * 16'h1010))
                $display("FAIL d3_drain %0d: dout=%h, want %h", i, obs_dout[2], 16'(i * 16'h1010));
            else n_pass++;
            do_pop();
        end
        n_checks++;
        if (obs_empty[2] !== 1'b1 || obs_dout[2] !== 16'h0 || obs_unf[2] !== 1'b0)
            $display("FAIL d3_drained: e=%b dout=%h u=%b, want 1 0 0", obs_empty[2], obs_dout[2], obs_unf[2]);
        else n_pass++;
        for (int i = 1; i <= 4; i++) do_push(16'(i * 16'h1111));
        n_checks++;
        if (obs_ovf[2] !== 1'b1 || obs_cnt[2] !== 4'd3 || obs_full[2] !== 1'b1 || obs_dout[2] !== 16'h4444)
            $display("FAIL d3_wrap: o=%b cnt=%0d f=%b dout=%h, want 1 3 1 4444", obs_ovf[2], obs_cnt[2], obs_full[2], obs_dout[2]);
        else n_pass++;
        for (int i = 4; i >= 2; i--) begin
            n_checks++;
            if (obs_dout[2] !== 16'(i * 16'h1111))
                $display("FAIL d3_wrap_pop %0d: dout=%h, want %h", i, obs_dout[2], 16'(i * 16'h1111));
            else n_pass++;
            do_pop();
        end
        n_checks++;
        if (obs_empty[2] !== 1'b1 || obs_dout[2] !== 16'h0)
            $display("FAIL d3_wrap_empty: e=%b dout=%h, want 1 0", obs_empty[2], obs_dout[2]);
        else n_pass++;
    endtask

    task automatic test_random();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int n = 0; n < 400; n++) begin
            bit r, c, pu, po;
            r  = ($urandom_range(0, 63) == 0);
            c  = ($urandom_range(0, 31) == 0);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            step(r, c, pu, po, 16'($urandom));
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_dout[k] !== model_top(k) || obs_cnt[k] !== 4'(m_cnt[k]) ||
                    obs_empty[k] !== (m_cnt[k] == 0) || obs_full[k] !== (m_cnt[k] == dep[k]) ||
                    obs_ovf[k] !== m_ovf[k] || obs_unf[k] !== m_unf[k])
                    $display("FAIL random[%0d] cyc %0d: dout=%h cnt=%0d e=%b f=%b o=%b u=%b, want %h %0d %b %b %b %b",
                             k, n, obs_dout[k], obs_cnt[k], obs_empty[k], obs_full[k], obs_ovf[k], obs_unf[k],
                             model_top(k), m_cnt[k], (m_cnt[k] == 0), (m_cnt[k] == dep[k]), m_ovf[k], m_unf[k]);
                else n_pass++;
            end
        end
    endtask

    // ---- main sequence and final report ----
    initial begin
        rst = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; din = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
        end
        #1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow_clear();
        test_replace();
        test_reset_priority();
        test_sweep_d3();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
